rf_arbiter: RTL and testbench
=============================

RF_ARBITER -- requirements
Module: rf_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, register data width.
REQ-002 Parameter ADDR_WIDTH, default 4, register address width.
REQ-003 Parameter RD_TIMEOUT, default 15, maximum RD_WAIT cycles before a read is aborted.
REQ-004 Parameter PROT_LIMIT, default 4, first address writable by M1 when protection is compiled in.
REQ-005 CLK  in  1  clock, all state on rising edge.
REQ-006 RST  in  1  reset RST, asynchronous, active-low.
REQ-007 Mx_Wr_En, Mx_Rd_En  in  1 each  request strobes from requester x (x = 0, 1).
REQ-008 Mx_Address  in  ADDR_WIDTH; Mx_Wr_Data  in  DATA_WIDTH  request payload.
REQ-009 Mx_Gnt  out  1  combinational accept; transfer occurs on a rising edge with request and Mx_Gnt both high.
REQ-010 Mx_RdData  out  DATA_WIDTH, registered; Mx_RdData_Valid  out  1, one-cycle pulse; Mx_Err  out  1, one-cycle pulse.
REQ-011 RF_Wr_En, RF_Rd_En  out  1; RF_Address  out  ADDR_WIDTH; RF_Wr_Data  out  DATA_WIDTH  registered register-file port.
REQ-012 RF_RdData  in  DATA_WIDTH; RF_RdData_Valid  in  1  register-file read return.

Function
REQ-013 FSM states IDLE, WR, RD, RD_WAIT.
REQ-014 Mx_Gnt is high only in IDLE, only for the requester chosen by round robin; at most one Mx_Gnt is high per cycle.
REQ-015 Round robin: one requester active -> it wins; both active -> non-last-granted wins; pointer updates on every accepted transfer.
REQ-016 IDLE, accepted write -> WR; RF_Wr_En=1, RF_Address and RF_Wr_Data = captured payload for exactly one cycle -> IDLE.
REQ-017 IDLE, accepted read -> RD; RF_Rd_En=1, RF_Address = captured address for one cycle -> RD_WAIT; owner id stored.
REQ-018 RD_WAIT with RF_RdData_Valid: owner Mx_RdData <= RF_RdData, owner Mx_RdData_Valid pulses the next cycle, -> IDLE.
REQ-019 RD_WAIT timeout counter counts from 0; at count RD_TIMEOUT-1 without valid: owner Mx_Err pulses, no RdData_Valid pulse, -> IDLE.
REQ-020 Mx_RdData holds its last value until the next completed read for that requester.
REQ-021 Requester asserting Wr_En and Rd_En together: write is performed, read dropped, Mx_Err pulses with the RF write cycle.
REQ-022 RF_RdData_Valid outside RD_WAIT is ignored, with no output change.
REQ-023 RF_* strobes and RF_Address/RF_Wr_Data are 0 in every cycle not in WR/RD.
REQ-024 Latency: accept edge -> RF strobe next cycle; minimum write spacing 2 cycles, minimum read turnaround 3 cycles.

Reset
REQ-025 RST low: state IDLE, priority pointer = M0, timeout counter 0, owner 0.
REQ-026 RST low: all RF_* outputs, Mx_RdData, Mx_RdData_Valid and Mx_Err are 0, applied immediately.
REQ-027 Reset mid-read aborts the read with no pulse; a later stray RF_RdData_Valid follows REQ-022.

Configuration
REQ-028 Macro RF_ARB_WR_PROTECT_EN defined: an M1 write with address < PROT_LIMIT is accepted and enters WR, RF_Wr_En stays 0, and M1_Err pulses; M0 writes are unrestricted.
REQ-029 Macro RF_ARB_WR_PROTECT_EN undefined: all writes are forwarded, and PROT_LIMIT has no effect.

Structure
REQ-030 Package rf_arb_pkg holds the FSM state encoding, requester id constants M0_ID/M1_ID and the default parameter values.
REQ-031 Sub-module rr_arbiter2 takes two requests and the pointer and returns a one-hot grant; the FSM and datapath stay in rf_arbiter.

Verification
REQ-032 M0 write addr 2 data 0x5A alone -> M0_Gnt same cycle; next cycle RF_Wr_En=1, RF_Address=2, RF_Wr_Data=0x5A, for one cycle.
REQ-033 M0 and M1 write together from reset -> M0 first, M1 granted in the next IDLE cycle (2 cycles later), alternating while both are held.
REQ-034 M1 read addr 5, RF returns 0xC3 2 cycles after RF_Rd_En -> M1_RdData=0xC3 with a one-cycle M1_RdData_Valid; M0 outputs unchanged.
REQ-035 M0 read, RF_RdData_Valid never returned -> after 15 RD_WAIT cycles M0_Err pulses and the FSM is in IDLE, then accepts a new request.
REQ-036 With RF_ARB_WR_PROTECT_EN, M1 write addr 1 -> M1_Gnt, no RF_Wr_En, M1_Err pulse; M1 write addr 4 -> forwarded normally.
REQ-037 RST low during RD_WAIT, then valid pulse after release -> no Mx_RdData_Valid, all outputs 0.

Source files
------------

// File: rtl/rf_arbiter_pkg.sv
// Shared types and constants for the two-requester register-file arbiter.
package rf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RD_WAIT = 2'd3
    } state_e;

    localparam logic M0_ID = 1'b0;
    localparam logic M1_ID = 1'b1;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int RD_TIMEOUT_DEF = 15;
    localparam int PROT_LIMIT_DEF = 4;

endpackage

// File: rtl/rf_arbiter_if.sv
// Requester-side bus: request strobes and payload in, grant and read/error returns out.
interface rf_arbiter_if
    import rf_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                  Wr_En;
    logic                  Rd_En;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] Wr_Data;
    logic                  Gnt;
    logic [DATA_WIDTH-1:0] RdData;
    logic                  RdData_Valid;
    logic                  Err;

    modport master (
        output Wr_En, Rd_En, Address, Wr_Data,
        input  Gnt, RdData, RdData_Valid, Err
    );

    modport slave (
        input  Wr_En, Rd_En, Address, Wr_Data,
        output Gnt, RdData, RdData_Valid, Err
    );
endinterface

// File: rtl/rf_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, on contention prio_i picks the winner.
module rr_arbiter2
    import rf_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic [1:0] gnt_o
);
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o         = 2'b00;
            gnt_o[prio_i] = 1'b1;
        end
    end
endmodule

// File: rtl/rf_arbiter.sv
// Arbitrates two requesters onto a single register-file port with read timeout.
// Optional M1 low-address write protection is enabled by defining RF_ARB_WR_PROTECT_EN.
module rf_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int RD_TIMEOUT = RD_TIMEOUT_DEF,
    parameter int PROT_LIMIT = PROT_LIMIT_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    rf_arbiter_if.slave           m0_if,
    rf_arbiter_if.slave           m1_if,
    output logic                  RF_Wr_En,
    output logic                  RF_Rd_En,
    output logic [ADDR_WIDTH-1:0] RF_Address,
    output logic [DATA_WIDTH-1:0] RF_Wr_Data,
    input  logic [DATA_WIDTH-1:0] RF_RdData,
    input  logic                  RF_RdData_Valid
);
    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
`ifdef RF_ARB_WR_PROTECT_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif

    state_e                       state_q, state_d;
    logic                         ptr_q, ptr_d;
    logic                         owner_q, owner_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         rf_wr_en_q, rf_wr_en_d;
    logic                         rf_rd_en_q, rf_rd_en_d;
    logic [ADDR_WIDTH-1:0]        rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0]        rf_wdata_q, rf_wdata_d;
    logic [1:0][DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]                   rd_vld_q, rd_vld_d;
    logic [1:0]                   err_q, err_d;

    logic [1:0]                   wr_en, rd_en, req, arb_gnt;
    logic [1:0][ADDR_WIDTH-1:0]   addr;
    logic [1:0][DATA_WIDTH-1:0]   wdata;
    logic                         idle, accept, sel, prot_hit;

    assign wr_en = {m1_if.Wr_En, m0_if.Wr_En};
    assign rd_en = {m1_if.Rd_En, m0_if.Rd_En};
    assign addr  = {m1_if.Address, m0_if.Address};
    assign wdata = {m1_if.Wr_Data, m0_if.Wr_Data};
    assign req   = wr_en | rd_en;

    rr_arbiter2 u_rr (
        .req_i  (req),
        .prio_i (ptr_q),
        .gnt_o  (arb_gnt)
    );

    assign idle     = (state_q == IDLE);
    assign accept   = idle && (arb_gnt != 2'b00);
    assign sel      = arb_gnt[1];
    // Folds to 0 when protection is not compiled in, so PROT_LIMIT is inert.
    assign prot_hit = PROT_ON && (sel == M1_ID) && (addr[sel] < ADDR_WIDTH'(PROT_LIMIT));

    assign m0_if.Gnt          = idle & arb_gnt[0];
    assign m1_if.Gnt          = idle & arb_gnt[1];
    assign m0_if.RdData       = rdata_q[0];
    assign m1_if.RdData       = rdata_q[1];
    assign m0_if.RdData_Valid = rd_vld_q[0];
    assign m1_if.RdData_Valid = rd_vld_q[1];
    assign m0_if.Err          = err_q[0];
    assign m1_if.Err          = err_q[1];

    assign RF_Wr_En   = rf_wr_en_q;
    assign RF_Rd_En   = rf_rd_en_q;
    assign RF_Address = rf_addr_q;
    assign RF_Wr_Data = rf_wdata_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = '0;
        rf_wr_en_d = 1'b0;
        rf_rd_en_d = 1'b0;
        rf_addr_d  = '0;
        rf_wdata_d = '0;
        rdata_d    = rdata_q;
        rd_vld_d   = 2'b00;
        err_d      = 2'b00;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ptr_d     = ~sel;
                    owner_d   = sel;
                    rf_addr_d = addr[sel];
                    // A simultaneous read strobe is dropped in favour of the write.
                    if (wr_en[sel]) begin
                        state_d      = WR;
                        rf_wr_en_d   = !prot_hit;
                        rf_wdata_d   = wdata[sel];
                        err_d[sel]   = rd_en[sel] | prot_hit;
                    end else begin
                        state_d    = RD;
                        rf_rd_en_d = 1'b1;
                    end
                end
            end
            WR:      state_d = IDLE;
            RD:      state_d = RD_WAIT;
            RD_WAIT: begin
                if (RF_RdData_Valid) begin
                    rdata_d[owner_q]  = RF_RdData;
                    rd_vld_d[owner_q] = 1'b1;
                    state_d           = IDLE;
                end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
                    err_d[owner_q] = 1'b1;
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            ptr_q      <= M0_ID;
            owner_q    <= M0_ID;
            cnt_q      <= '0;
            rf_wr_en_q <= 1'b0;
            rf_rd_en_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
            rdata_q    <= '0;
            rd_vld_q   <= 2'b00;
            err_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            rf_wr_en_q <= rf_wr_en_d;
            rf_rd_en_q <= rf_rd_en_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
            rdata_q    <= rdata_d;
            rd_vld_q   <= rd_vld_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_rf_arbiter.sv
// Directed bench for rf_arbiter: writes, round robin, reads, timeout, dual strobe, protection, reset.
module tb_rf_arbiter;
    import rf_arb_pkg::*;

    logic       CLK;
    logic       RST;
    logic       RF_Wr_En, RF_Rd_En;
    logic [3:0] RF_Address;
    logic [7:0] RF_Wr_Data;
    logic [7:0] RF_RdData;
    logic       RF_RdData_Valid;

    int errors = 0;
    int checks = 0;

    rf_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) m0 ();
    rf_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) m1 ();

    rf_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RD_TIMEOUT(15), .PROT_LIMIT(4)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .m0_if           (m0),
        .m1_if           (m1),
        .RF_Wr_En        (RF_Wr_En),
        .RF_Rd_En        (RF_Rd_En),
        .RF_Address      (RF_Address),
        .RF_Wr_Data      (RF_Wr_Data),
        .RF_RdData       (RF_RdData),
        .RF_RdData_Valid (RF_RdData_Valid)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        m0.Wr_En = 0; m0.Rd_En = 0; m0.Address = '0; m0.Wr_Data = '0;
        m1.Wr_En = 0; m1.Rd_En = 0; m1.Address = '0; m1.Wr_Data = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rf"}, {RF_Wr_En, RF_Rd_En, RF_Address, RF_Wr_Data}, 32'h0);
        chk({tag, "_m0"}, {m0.RdData, m0.RdData_Valid, m0.Err}, 32'h0);
        chk({tag, "_m1"}, {m1.RdData, m1.RdData_Valid, m1.Err}, 32'h0);
    endtask

    initial begin
        RST = 1'b1;
        RF_RdData = '0;
        RF_RdData_Valid = 1'b0;
        idle_inputs();
        #1 RST = 1'b0;
        #1;
        chk_all_zero("reset");
        chk("reset_gnt", {m0.Gnt, m1.Gnt}, 2'b00);
        cyc(); cyc();
        RST = 1'b1;

        // Single M0 write
        m0.Wr_En = 1; m0.Address = 4'd2; m0.Wr_Data = 8'h5A;
        #1 chk("wr_gnt", {m0.Gnt, m1.Gnt}, 2'b10);
        cyc();
        idle_inputs();
        #1 chk("wr_rf", {RF_Wr_En, RF_Rd_En, RF_Address, RF_Wr_Data}, {1'b1, 1'b0, 4'd2, 8'h5A});
        chk("wr_nognt", {m0.Gnt, m1.Gnt}, 2'b00);
        cyc();
        chk("wr_done", {RF_Wr_En, RF_Rd_En, RF_Address, RF_Wr_Data}, 32'h0);

        // Round robin from reset
        RST = 1'b0; #1; cyc(); RST = 1'b1;
        m0.Wr_En = 1; m0.Address = 4'd3; m0.Wr_Data = 8'h11;
        m1.Wr_En = 1; m1.Address = 4'd7; m1.Wr_Data = 8'h22;
        #1 chk("rr_first", {m0.Gnt, m1.Gnt}, 2'b10);
        cyc();
        chk("rr_wr0", {RF_Wr_En, RF_Address, RF_Wr_Data}, {1'b1, 4'd3, 8'h11});
        chk("rr_busy", {m0.Gnt, m1.Gnt}, 2'b00);
        cyc();
        chk("rr_second", {m0.Gnt, m1.Gnt}, 2'b01);
        cyc();
        chk("rr_wr1", {RF_Wr_En, RF_Address, RF_Wr_Data}, {1'b1, 4'd7, 8'h22});
        cyc();
        chk("rr_third", {m0.Gnt, m1.Gnt}, 2'b10);
        cyc();
        idle_inputs();
        #1 chk("rr_wr2", {RF_Wr_En, RF_Address, RF_Wr_Data}, {1'b1, 4'd3, 8'h11});
        cyc();

        // M1 read, data returned two cycles after the strobe
        m1.Rd_En = 1; m1.Address = 4'd5;
        #1 chk("rd_gnt", {m0.Gnt, m1.Gnt}, 2'b01);
        cyc();
        idle_inputs();
        #1 chk("rd_rf", {RF_Wr_En, RF_Rd_En, RF_Address, RF_Wr_Data}, {1'b0, 1'b1, 4'd5, 8'h00});
        cyc();
        chk("rd_strobe_off", {RF_Rd_En, RF_Address}, 5'h0);
        cyc();
        RF_RdData = 8'hC3; RF_RdData_Valid = 1;
        cyc();
        RF_RdData_Valid = 0; RF_RdData = 8'h00;
        chk("rd_data", {m1.RdData, m1.RdData_Valid, m1.Err}, {8'hC3, 1'b1, 1'b0});
        chk("rd_m0_quiet", {m0.RdData, m0.RdData_Valid, m0.Err}, 10'h0);
        cyc();
        chk("rd_hold", {m1.RdData, m1.RdData_Valid}, {8'hC3, 1'b0});

        // Stray valid while idle
        RF_RdData = 8'hFF; RF_RdData_Valid = 1;
        cyc();
        RF_RdData_Valid = 0;
        chk("stray", {m1.RdData, m1.RdData_Valid, m0.RdData, m0.RdData_Valid}, {8'hC3, 1'b0, 8'h00, 1'b0});

        // M0 read timeout
        m0.Rd_En = 1; m0.Address = 4'd9;
        #1 chk("to_gnt", {m0.Gnt, m1.Gnt}, 2'b10);
        cyc();
        idle_inputs();
        #1 chk("to_rf", {RF_Rd_En, RF_Address}, {1'b1, 4'd9});
        for (int i = 0; i < 15; i++) begin
            cyc();
            chk($sformatf("to_wait%0d", i), {m0.Err, m0.Gnt}, 2'b00);
        end
        cyc();
        m0.Wr_En = 1; m0.Address = 4'd1; m0.Wr_Data = 8'h77;
        #1 chk("to_err", {m0.Err, m0.RdData_Valid, m0.Gnt}, 3'b101);
        cyc();
        idle_inputs();
        #1 chk("to_next", {m0.Err, RF_Wr_En, RF_Address, RF_Wr_Data}, {1'b0, 1'b1, 4'd1, 8'h77});
        cyc();

        // Write and read strobed together
        m1.Wr_En = 1; m1.Rd_En = 1; m1.Address = 4'd6; m1.Wr_Data = 8'h3C;
        #1 chk("dual_gnt", {m0.Gnt, m1.Gnt}, 2'b01);
        cyc();
        idle_inputs();
        #1 chk("dual_wr", {RF_Wr_En, RF_Rd_En, RF_Address, RF_Wr_Data, m1.Err}, {1'b1, 1'b0, 4'd6, 8'h3C, 1'b1});
        cyc();
        chk("dual_after", {RF_Rd_En, m1.Err}, 2'b00);
        cyc();
        chk("dual_noread", {RF_Rd_En, RF_Wr_En}, 2'b00);

        // M1 low-address write
        m1.Wr_En = 1; m1.Address = 4'd1; m1.Wr_Data = 8'h99;
        #1 chk("prot_gnt", {m0.Gnt, m1.Gnt}, 2'b01);
        cyc();
        idle_inputs();
`ifdef RF_ARB_WR_PROTECT_EN
        #1 chk("prot_block", {RF_Wr_En, m1.Err}, 2'b01);
`else
        #1 chk("prot_fwd", {RF_Wr_En, RF_Address, RF_Wr_Data, m1.Err}, {1'b1, 4'd1, 8'h99, 1'b0});
`endif
        cyc();
        m1.Wr_En = 1; m1.Address = 4'd4; m1.Wr_Data = 8'h44;
        cyc();
        idle_inputs();
        #1 chk("prot_ok", {RF_Wr_En, RF_Address, RF_Wr_Data, m1.Err}, {1'b1, 4'd4, 8'h44, 1'b0});
        cyc();

        // Reset during RD_WAIT
        m0.Rd_En = 1; m0.Address = 4'd2;
        cyc();
        idle_inputs();
        cyc();
        cyc();
        RST = 1'b0;
        #1 chk_all_zero("rst_mid");
        cyc();
        RST = 1'b1;
        RF_RdData = 8'hAB; RF_RdData_Valid = 1;
        cyc();
        RF_RdData_Valid = 0;
        chk_all_zero("rst_stray");
        chk("rst_gnt", {m0.Gnt, m1.Gnt}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
